// File: rtl/sme_job_arbiter.sv
// rtl/sme_job_arbiter.sv - round-robin scheduler sharing one string-match engine between NREQ requesters
module sme_job_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [6*NREQ-1:0]   req_str_len,
  input  logic [4*NREQ-1:0]   req_pat_len,
  output logic [5:0]          buf_addr,
  input  logic [8*NREQ-1:0]   buf_data,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic                res_match,
  output logic [4:0]          res_index,
  output logic                res_err,
  output logic [7:0]          eng_chardata,
  output logic                eng_isstring,
  output logic                eng_ispattern,
  input  logic                eng_valid,
  input  logic                eng_match,
  input  logic [4:0]          eng_match_index
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  // The completion cycle is spent in IDLE with done high, so a new grant can follow one cycle later.
  typedef enum logic [2:0] {
    S_IDLE,
    S_STR,
    S_PAT,
    S_WAIT,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_next;
  logic [5:0]      k_q;
  logic [7:0]      wcnt_q;
  logic [5:0]      slen_q;
  logic [3:0]      plen_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [5:0]      win_str_len;
  logic [3:0]      win_pat_len;
  logic            win_legal;
  logic            str_last;
  logic            pat_last;
  logic            wait_timeout;
  logic            finish;
  logic [7:0]      sel_data;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(rr_ptr_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_str_len  = req_str_len[6*int'(win_idx) +: 6];
  assign win_pat_len  = req_pat_len[4*int'(win_idx) +: 4];
  assign win_legal    = (win_str_len != 6'd0) && (win_str_len <= 6'd32) &&
                        (win_pat_len != 4'd0) && (win_pat_len <= 4'd8);
  assign str_last     = (k_q == slen_q - 6'd1);
  assign pat_last     = (k_q == {2'b00, plen_q} - 6'd1);
  assign wait_timeout = (wcnt_q == 8'(TIMEOUT));
  assign finish       = (state_q == S_ERR) || ((state_q == S_WAIT) && (eng_valid || wait_timeout));
  assign rr_next      = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
  assign sel_data     = buf_data[8*int'(gidx_q) +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_found) state_d = win_legal ? S_STR : S_ERR;
      S_STR:  if (str_last) state_d = S_PAT;
      S_PAT:  if (pat_last) state_d = S_WAIT;
      S_WAIT: if (eng_valid || wait_timeout) state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      done      <= '0;
      res_match <= 1'b0;
      res_index <= '0;
      res_err   <= 1'b0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      k_q       <= '0;
      wcnt_q    <= '0;
      slen_q    <= '0;
      plen_q    <= '0;
    end else begin
      done <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            gnt    <= NREQ'(1) << win_idx;
            gidx_q <= win_idx;
            slen_q <= win_str_len;
            plen_q <= win_pat_len;
            k_q    <= '0;
          end
        end
        S_STR: k_q <= str_last ? 6'd0 : k_q + 6'd1;
        S_PAT: begin
          k_q    <= k_q + 6'd1;
          wcnt_q <= '0;
        end
        S_WAIT: wcnt_q <= wcnt_q + 8'd1;
        default: ;
      endcase
      // Results are only rewritten on completion, so they stay stable between done pulses.
      if (finish) begin
        gnt       <= '0;
        done      <= NREQ'(1) << gidx_q;
        rr_ptr_q  <= rr_next;
        res_err   <= (state_q == S_ERR) || !eng_valid;
        res_match <= (state_q == S_WAIT) && eng_valid && eng_match;
        res_index <= ((state_q == S_WAIT) && eng_valid) ? eng_match_index : 5'd0;
      end
    end
  end

  always_comb begin
    buf_addr      = '0;
    eng_chardata  = '0;
    eng_isstring  = 1'b0;
    eng_ispattern = 1'b0;
    case (state_q)
      S_STR: begin
        buf_addr     = k_q;
        eng_isstring = 1'b1;
        eng_chardata = sel_data;
      end
      S_PAT: begin
        buf_addr      = 6'd32 + k_q;
        eng_ispattern = 1'b1;
        eng_chardata  = sel_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sme_job_arbiter.sv
// tb/tb_sme_job_arbiter.sv - randomized self-checking bench for sme_job_arbiter with behavioural engine model
module tb_sme_job_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 255;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [6*NREQ-1:0]   req_str_len;
  logic [4*NREQ-1:0]   req_pat_len;
  logic [5:0]          buf_addr;
  logic [8*NREQ-1:0]   buf_data;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic                res_match;
  logic [4:0]          res_index;
  logic                res_err;
  logic [7:0]          eng_chardata;
  logic                eng_isstring;
  logic                eng_ispattern;
  logic                eng_valid;
  logic                eng_match;
  logic [4:0]          eng_match_index;

  logic [7:0] mem [NREQ][64];
  int str_len [NREQ];
  int pat_len [NREQ];

  int n_cmp, n_bad;
  int m_ptr;
  int overlap_n, proto_bad;
  int done_cnt [NREQ];

  logic [7:0]      o_str [$];
  logic [7:0]      o_pat [$];
  int              o_t_gnt, o_t_done, o_wait, o_nstrobe, o_addr_bad;
  bit              o_gap, o_timed_out;
  logic [NREQ-1:0] o_gnt, o_done;
  logic            o_match, o_err;
  logic [4:0]      o_index;

  sme_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_str_len(req_str_len), .req_pat_len(req_pat_len),
    .buf_addr(buf_addr), .buf_data(buf_data), .gnt(gnt), .done(done),
    .res_match(res_match), .res_index(res_index), .res_err(res_err),
    .eng_chardata(eng_chardata), .eng_isstring(eng_isstring), .eng_ispattern(eng_ispattern),
    .eng_valid(eng_valid), .eng_match(eng_match), .eng_match_index(eng_match_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_str_len = '0;
    req_pat_len = '0;
    buf_data    = '0;
    for (int r = 0; r < NREQ; r++) begin
      req_str_len[6*r +: 6] = 6'(str_len[r]);
      req_pat_len[4*r +: 4] = 4'(pat_len[r]);
      buf_data[8*r +: 8]    = mem[r][buf_addr];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(gnt) > 1) overlap_n++;
      if (eng_isstring && eng_ispattern) proto_bad++;
      if (!eng_isstring && !eng_ispattern && (eng_chardata != 8'd0 || buf_addr != 6'd0)) proto_bad++;
      if (done != '0 && gnt != '0) proto_bad++;
      for (int r = 0; r < NREQ; r++) if (done[r]) done_cnt[r]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First occurrence search: the engine's behaviour expressed directly.
  function automatic void find(input logic [7:0] s [$], input logic [7:0] p [$], output logic m, output int idx);
    bit ok;
    m = 1'b0;
    idx = 0;
    for (int i = 0; i + p.size() <= s.size(); i++) begin
      ok = 1'b1;
      for (int j = 0; j < p.size(); j++) if (s[i+j] != p[j]) ok = 1'b0;
      if (ok && !m) begin
        m = 1'b1;
        idx = i;
      end
    end
  endfunction

  function automatic void expect_from_mem(input int r, output logic m, output int idx);
    logic [7:0] s [$];
    logic [7:0] p [$];
    for (int i = 0; i < str_len[r]; i++) s.push_back(mem[r][i]);
    for (int i = 0; i < pat_len[r]; i++) p.push_back(mem[r][32+i]);
    find(s, p, m, idx);
  endfunction

  function automatic int winner(input logic [NREQ-1:0] rv);
    for (int i = 0; i < NREQ; i++) if (rv[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  function automatic bit legal(input int r);
    return str_len[r] >= 1 && str_len[r] <= 32 && pat_len[r] >= 1 && pat_len[r] <= 8;
  endfunction

  task automatic fill_rand(input int r);
    for (int i = 0; i < 64; i++) mem[r][i] = 8'(8'h61 + $urandom_range(0, 2));
    str_len[r] = $urandom_range(1, 32);
    pat_len[r] = $urandom_range(1, 4);
  endtask

  // Drives the engine side of one job and records what the DUT did; no judging here.
  task automatic serve_job(input int lat, input bit hang, input bit drop_req);
    int first_s, last_s, wstart;
    bit seen_pat, in_wait, fired;
    logic em;
    int ei;
    o_str.delete(); o_pat.delete();
    o_t_gnt = -1; o_t_done = -1; o_wait = -1; o_nstrobe = 0; o_addr_bad = 0;
    o_gnt = '0; o_done = '0; o_match = 1'b0; o_err = 1'b0; o_index = '0;
    first_s = -1; last_s = -1; wstart = 0; seen_pat = 0; in_wait = 0; fired = 0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      step();
      if (fired) begin
        eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = '0; fired = 0;
      end
      if (o_t_gnt < 0 && gnt != '0) begin
        o_t_gnt = cyc;
        o_gnt = gnt;
        if (drop_req) req = '0;
      end
      if (done != '0) begin
        o_t_done = cyc; o_done = done; o_match = res_match; o_index = res_index; o_err = res_err;
        if (in_wait) o_wait = cyc - wstart;
        break;
      end
      if (eng_isstring) begin
        if (buf_addr !== 6'(o_str.size())) o_addr_bad++;
        o_str.push_back(eng_chardata);
        o_nstrobe++;
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
      end else if (eng_ispattern) begin
        if (buf_addr !== 6'(32 + o_pat.size())) o_addr_bad++;
        o_pat.push_back(eng_chardata);
        seen_pat = 1;
        o_nstrobe++;
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
      end else if (seen_pat && !in_wait) begin
        in_wait = 1;
        wstart = cyc;
      end
      if (in_wait && !hang && !fired && cyc - wstart == lat) begin
        find(o_str, o_pat, em, ei);
        eng_valid = 1'b1; eng_match = em; eng_match_index = 5'(ei); fired = 1;
      end
    end
    eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = '0;
    o_timed_out = (o_t_done < 0);
    o_gap = (o_nstrobe > 0) && (last_s - first_s + 1 != o_nstrobe);
  endtask

  task automatic test_reset();
    n_cmp++; if ({gnt, done} !== '0) begin n_bad++; $display("FAIL reset_gnt_done: got %0h want 0", {gnt, done}); end
    n_cmp++; if ({res_match, res_index, res_err} !== 7'd0) begin n_bad++; $display("FAIL reset_results: got %0h want 0", {res_match, res_index, res_err}); end
    n_cmp++; if ({buf_addr, eng_chardata, eng_isstring, eng_ispattern} !== 16'd0) begin n_bad++; $display("FAIL reset_engine_if: got %0h want 0", {buf_addr, eng_chardata, eng_isstring, eng_ispattern}); end
  endtask

  task automatic test_single();
    string s, p;
    int lat;
    s = "abcabc"; p = "ca";
    for (int i = 0; i < 6; i++) mem[0][i] = s[i];
    for (int i = 0; i < 2; i++) mem[0][32+i] = p[i];
    str_len[0] = 6; pat_len[0] = 2;
    lat = $urandom_range(0, 5);
    req = 2'b01;
    serve_job(lat, 0, 0);
    req = '0;
    m_ptr = 1;
    n_cmp++; if (o_timed_out) begin n_bad++; $display("FAIL single_bound: got no done want done"); end
    n_cmp++; if (o_t_gnt !== 1 || o_gnt !== 2'b01) begin n_bad++; $display("FAIL single_gnt: got %0h at %0d want 1 at 1", o_gnt, o_t_gnt); end
    n_cmp++; if (o_str.size() !== 6 || o_pat.size() !== 2) begin n_bad++; $display("FAIL single_lens: got %0d/%0d want 6/2", o_str.size(), o_pat.size()); end
    n_cmp++; if (o_pat.size() == 2 && {o_pat[0], o_pat[1]} !== 16'h6361) begin n_bad++; $display("FAIL single_pat_bytes: got %0h want 6361", {o_pat[0], o_pat[1]}); end
    n_cmp++; if (o_gap || o_addr_bad != 0) begin n_bad++; $display("FAIL single_stream: got gap=%0d addr_bad=%0d want 0/0", o_gap, o_addr_bad); end
    n_cmp++; if (o_wait !== lat + 1) begin n_bad++; $display("FAIL single_done_latency: got %0d want %0d", o_wait, lat + 1); end
    n_cmp++; if ({o_done, o_match, o_index, o_err} !== {2'b01, 1'b1, 5'd2, 1'b0}) begin n_bad++; $display("FAIL single_result: got %0h want %0h", {o_done, o_match, o_index, o_err}, {2'b01, 1'b1, 5'd2, 1'b0}); end
    step(); step(); step();
    n_cmp++; if ({done, res_match, res_index, res_err} !== {2'b00, 1'b1, 5'd2, 1'b0}) begin n_bad++; $display("FAIL single_hold: got %0h want %0h", {done, res_match, res_index, res_err}, {2'b00, 1'b1, 5'd2, 1'b0}); end
  endtask

  task automatic test_contention();
    int w, lat, ei, c0 [NREQ];
    logic em;
    fill_rand(0); fill_rand(1);
    for (int r = 0; r < NREQ; r++) c0[r] = done_cnt[r];
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      w = winner(req);
      lat = $urandom_range(0, 6);
      serve_job(lat, 0, 0);
      if (j == 3) req = '0;
      expect_from_mem(w, em, ei);
      n_cmp++; if (o_t_gnt !== 1 || o_gnt !== NREQ'(1) << w) begin n_bad++; $display("FAIL contention_gnt: got %0h at %0d want %0h at 1", o_gnt, o_t_gnt, NREQ'(1) << w); end
      n_cmp++; if ({o_done, o_match, o_index, o_err} !== {NREQ'(1) << w, em, 5'(ei), 1'b0}) begin n_bad++; $display("FAIL contention_result: got %0h want %0h", {o_done, o_match, o_index, o_err}, {NREQ'(1) << w, em, 5'(ei), 1'b0}); end
      m_ptr = (w + 1) % NREQ;
    end
    step(); step();
    n_cmp++; if (done_cnt[0] - c0[0] !== 2 || done_cnt[1] - c0[1] !== 2) begin n_bad++; $display("FAIL contention_done_count: got %0d/%0d want 2/2", done_cnt[0] - c0[0], done_cnt[1] - c0[1]); end
  endtask

  task automatic test_len_err();
    int w;
    str_len[1] = 0; pat_len[1] = 3;
    str_len[0] = 5; pat_len[0] = 9;
    req = 2'b10;
    for (int j = 0; j < 3; j++) begin
      w = winner(req);
      serve_job(0, 0, 0);
      if (j == 0) begin
        req = 2'b11;
        str_len[1] = 33;
      end
      if (j == 2) req = '0;
      n_cmp++; if (o_gnt !== NREQ'(1) << w || o_t_gnt !== 1) begin n_bad++; $display("FAIL len_err_gnt: got %0h at %0d want %0h at 1", o_gnt, o_t_gnt, NREQ'(1) << w); end
      n_cmp++; if (o_t_done !== 2 || o_nstrobe !== 0) begin n_bad++; $display("FAIL len_err_timing: got done@%0d strobes=%0d want done@2 strobes=0", o_t_done, o_nstrobe); end
      n_cmp++; if ({o_done, o_match, o_index, o_err} !== {NREQ'(1) << w, 1'b0, 5'd0, 1'b1}) begin n_bad++; $display("FAIL len_err_result: got %0h want %0h", {o_done, o_match, o_index, o_err}, {NREQ'(1) << w, 1'b0, 5'd0, 1'b1}); end
      m_ptr = (w + 1) % NREQ;
    end
    step();
  endtask

  task automatic test_timeout();
    int w, ei;
    logic em;
    fill_rand(0); fill_rand(1);
    req = 2'b11;
    w = winner(req);
    serve_job(0, 1, 0);
    m_ptr = (w + 1) % NREQ;
    n_cmp++; if (o_wait !== TIMEOUT + 1) begin n_bad++; $display("FAIL timeout_latency: got %0d want %0d", o_wait, TIMEOUT + 1); end
    n_cmp++; if ({o_done, o_match, o_err} !== {NREQ'(1) << w, 1'b0, 1'b1}) begin n_bad++; $display("FAIL timeout_result: got %0h want %0h", {o_done, o_match, o_err}, {NREQ'(1) << w, 1'b0, 1'b1}); end
    w = winner(req);
    serve_job(2, 0, 0);
    req = '0;
    m_ptr = (w + 1) % NREQ;
    expect_from_mem(w, em, ei);
    n_cmp++; if ({o_gnt, o_done, o_match, o_index, o_err} !== {NREQ'(1) << w, NREQ'(1) << w, em, 5'(ei), 1'b0}) begin n_bad++; $display("FAIL timeout_next_job: got %0h want %0h", {o_gnt, o_done, o_match, o_index, o_err}, {NREQ'(1) << w, NREQ'(1) << w, em, 5'(ei), 1'b0}); end
    step();
  endtask

  task automatic test_boundary();
    int r, lat, ei, bad;
    logic em;
    r = $urandom_range(0, 1);
    fill_rand(r);
    str_len[r] = 32; pat_len[r] = 8;
    for (int i = 0; i < 8; i++) mem[r][32+i] = mem[r][24+i];
    lat = $urandom_range(0, 4);
    req = NREQ'(1) << r;
    serve_job(lat, 0, 1);
    m_ptr = (r + 1) % NREQ;
    expect_from_mem(r, em, ei);
    bad = 0;
    for (int i = 0; i < o_str.size() && i < 32; i++) if (o_str[i] !== mem[r][i]) bad++;
    n_cmp++; if (o_str.size() !== 32 || o_pat.size() !== 8 || o_nstrobe !== 40) begin n_bad++; $display("FAIL boundary_counts: got %0d/%0d/%0d want 32/8/40", o_str.size(), o_pat.size(), o_nstrobe); end
    n_cmp++; if (o_gap || o_addr_bad != 0 || bad != 0) begin n_bad++; $display("FAIL boundary_stream: got gap=%0d addr_bad=%0d byte_bad=%0d want 0/0/0", o_gap, o_addr_bad, bad); end
    n_cmp++; if ({o_done, o_match, o_index, o_err} !== {NREQ'(1) << r, em, 5'(ei), 1'b0} || o_wait !== lat + 1) begin n_bad++; $display("FAIL boundary_result: got %0h wait %0d want %0h wait %0d", {o_done, o_match, o_index, o_err}, o_wait, {NREQ'(1) << r, em, 5'(ei), 1'b0}, lat + 1); end
    step();
  endtask

  task automatic test_random();
    int w, lat, ei, bad;
    logic em;
    for (int j = 0; j < 8; j++) begin
      for (int r = 0; r < NREQ; r++) begin
        fill_rand(r);
        if ($urandom_range(0, 4) == 0) str_len[r] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63);
        if ($urandom_range(0, 4) == 0) pat_len[r] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15);
      end
      req = NREQ'($urandom_range(1, 3));
      w = winner(req);
      lat = $urandom_range(0, 5);
      serve_job(lat, 0, 0);
      req = '0;
      m_ptr = (w + 1) % NREQ;
      n_cmp++; if (o_gnt !== NREQ'(1) << w || o_t_gnt !== 1) begin n_bad++; $display("FAIL random_gnt: got %0h at %0d want %0h at 1", o_gnt, o_t_gnt, NREQ'(1) << w); end
      if (legal(w)) begin
        expect_from_mem(w, em, ei);
        bad = 0;
        for (int i = 0; i < o_str.size() && i < 32; i++) if (o_str[i] !== mem[w][i]) bad++;
        n_cmp++; if (o_str.size() !== str_len[w] || o_pat.size() !== pat_len[w] || bad != 0 || o_addr_bad != 0 || o_gap) begin n_bad++; $display("FAIL random_stream: got %0d/%0d bad=%0d want %0d/%0d bad=0", o_str.size(), o_pat.size(), bad + o_addr_bad, str_len[w], pat_len[w]); end
        n_cmp++; if ({o_done, o_match, o_index, o_err} !== {NREQ'(1) << w, em, 5'(ei), 1'b0} || o_wait !== lat + 1) begin n_bad++; $display("FAIL random_result: got %0h wait %0d want %0h wait %0d", {o_done, o_match, o_index, o_err}, o_wait, {NREQ'(1) << w, em, 5'(ei), 1'b0}, lat + 1); end
      end else begin
        n_cmp++; if ({o_done, o_match, o_index, o_err} !== {NREQ'(1) << w, 1'b0, 5'd0, 1'b1} || o_t_done !== 2 || o_nstrobe !== 0) begin n_bad++; $display("FAIL random_err: got %0h done@%0d strobes=%0d want %0h done@2 strobes=0", {o_done, o_match, o_index, o_err}, o_t_done, o_nstrobe, {NREQ'(1) << w, 1'b0, 5'd0, 1'b1}); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int t, bad;
    fill_rand(0); fill_rand(1);
    str_len[0] = 20; str_len[1] = 20;
    req = 2'b01;
    serve_job(0, 0, 0);
    req = '0;
    m_ptr = 1;
    step();
    req = 2'b11;
    t = 0;
    while (gnt == '0 && t < 10) begin step(); t++; end
    n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL reset_mid_pre_gnt: got %0h want 2", gnt); end
    for (int i = 0; i < 10; i++) step();
    n_cmp++; if (buf_addr !== 6'd10 || eng_isstring !== 1'b1) begin n_bad++; $display("FAIL reset_mid_byte10: got addr %0d str %0d want 10 1", buf_addr, eng_isstring); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({gnt, done, eng_isstring, eng_ispattern} !== '0) begin n_bad++; $display("FAIL reset_mid_clear: got %0h want 0", {gnt, done, eng_isstring, eng_ispattern}); end
    step(); step();
    reset = 1'b0;
    m_ptr = 0;
    serve_job(1, 0, 0);
    req = '0;
    bad = 0;
    for (int i = 0; i < o_str.size() && i < 32; i++) if (o_str[i] !== mem[0][i]) bad++;
    n_cmp++; if (o_gnt !== 2'b01 || o_t_gnt !== 1) begin n_bad++; $display("FAIL reset_mid_rr_ptr: got %0h at %0d want 1 at 1", o_gnt, o_t_gnt); end
    n_cmp++; if (o_str.size() !== 20 || bad != 0 || o_addr_bad != 0 || o_done !== 2'b01) begin n_bad++; $display("FAIL reset_mid_restart: got len %0d bad %0d done %0h want 20 0 1", o_str.size(), bad + o_addr_bad, o_done); end
    step();
  endtask

  task automatic test_monitors();
    n_cmp++; if (overlap_n !== 0) begin n_bad++; $display("FAIL gnt_overlap: got %0d want 0", overlap_n); end
    n_cmp++; if (proto_bad !== 0) begin n_bad++; $display("FAIL idle_engine_if: got %0d want 0", proto_bad); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_ptr = 0; overlap_n = 0; proto_bad = 0;
    for (int r = 0; r < NREQ; r++) begin
      done_cnt[r] = 0;
      fill_rand(r);
    end
    reset = 1'b1; req = '0;
    eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = '0;
    step(); step(); step();
    test_reset();
    reset = 1'b0;
    step();
    test_single();
    test_contention();
    test_len_err();
    test_timeout();
    test_boundary();
    test_random();
    test_reset_mid();
    test_monitors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
